// File: rtl/mpu_sched_pkg.sv
// Shared types and constants for the MPU-6050 read scheduler.
// State encoding, bus widths and the byte substituted for a read that never completes.
package mpu_sched_pkg;

  localparam int SEL_W  = 4;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    STORE     = 3'd4,
    PUBLISH   = 3'd5
  } state_t;

endpackage

// File: rtl/mpu_tick_gen.sv
// Frame tick generator: counts 0..PERIOD_CYCLES-1 while enabled, pulses tick on the last count.
// Latency: tick is combinational from the count register; no backpressure, held at 0 while disabled.
module mpu_tick_gen #(
  parameter int PERIOD_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  if (PERIOD_CYCLES < 2) begin : g_bad_period
    $error("mpu_tick_gen: PERIOD_CYCLES must be >= 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == LAST_CNT);

endmodule

// File: rtl/mpu_read_scheduler.sv
// Periodic register-read sequencer for the MPU-6050 I2C wrapper; publishes double-buffered frames.
// Optional per-read watchdog and timeout_err port enabled by defining MPU_SCHED_TIMEOUT_EN.
module mpu_read_scheduler
  import mpu_sched_pkg::*;
#(
  parameter int NUM_REGS       = 14,
  parameter int FIRST_SEL      = 0,
  parameter int PERIOD_CYCLES  = 100000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              i2c_en,
  output logic [SEL_W-1:0]  i2c_sel,
  input  logic              i2c_done,
  input  logic [DATA_W-1:0] i2c_data,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_valid,
  output logic [15:0]       frame_count,
  output logic              overrun,
`ifdef MPU_SCHED_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);

  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NUM_REGS - 1);
  localparam logic [SEL_W-1:0] FIRST_SEL_V = SEL_W'(FIRST_SEL);
  localparam logic [SEL_W:0]   NUM_REGS_X  = (SEL_W + 1)'(NUM_REGS);

  if (NUM_REGS < 1 || NUM_REGS > 16 || FIRST_SEL < 0 || FIRST_SEL + NUM_REGS > 16 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mpu_read_scheduler: invalid NUM_REGS/FIRST_SEL/TIMEOUT_CYCLES");
  end

  state_t              state, state_nxt;
  logic                tick;
  logic [SEL_W-1:0]    idx;
  logic [DATA_W-1:0]   shadow [16];
  logic [DATA_W-1:0]   bank   [16];
  logic                rd_done;
  logic [DATA_W-1:0]   rd_byte;
  logic                last_read;

  mpu_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .tick  (tick)
  );

`ifdef MPU_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
      if (wd_expired && !i2c_done) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign wd_expired = (state == WAIT_DONE) && (wd_cnt == WD_LAST);
  // A real response in the expiry cycle still wins over the fill byte.
  assign rd_done    = (state == WAIT_DONE) && (i2c_done || wd_expired);
  assign rd_byte    = i2c_done ? i2c_data : TIMEOUT_FILL;
`else
  assign rd_done    = (state == WAIT_DONE) && i2c_done;
  assign rd_byte    = i2c_data;
`endif

  assign last_read = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable) state_nxt = WAIT_TICK;
      WAIT_TICK: begin
        if (!enable)   state_nxt = IDLE;
        else if (tick) state_nxt = ISSUE;
      end
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (rd_done) state_nxt = STORE;
      STORE: begin
        if (!enable)       state_nxt = IDLE;
        else if (last_read) state_nxt = PUBLISH;
        else               state_nxt = ISSUE;
      end
      PUBLISH:   state_nxt = enable ? WAIT_TICK : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        shadow[i] <= '0;
        bank[i]   <= '0;
      end
    end else begin
      state <= state_nxt;
      if (tick && busy) begin
        overrun <= 1'b1;
      end
      if (state_nxt == IDLE || state_nxt == WAIT_TICK) begin
        idx <= '0;
      end else if (state == STORE && state_nxt == ISSUE) begin
        idx <= idx + 1'b1;
      end
      if (rd_done) begin
        shadow[idx] <= rd_byte;
      end
      // Bank is swapped on entry to PUBLISH so the new frame is readable during the strobe.
      if (state == STORE && state_nxt == PUBLISH) begin
        bank        <= shadow;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign i2c_en      = (state == ISSUE);
  assign i2c_sel     = FIRST_SEL_V + idx;
  assign frame_valid = (state == PUBLISH);
  assign busy        = !(state == IDLE || state == WAIT_TICK);
  assign rd_data     = ({1'b0, rd_addr} < NUM_REGS_X) ? bank[rd_addr] : '0;

endmodule

// File: tb/tb_mpu_read_scheduler.sv
// Directed bench for mpu_read_scheduler with a wrapper model answering data=0xA0+sel.
// Build with MPU_SCHED_TIMEOUT_EN defined to include the watchdog scenario.
module tb_mpu_read_scheduler;

  localparam int NREG   = 14;
  localparam int PERIOD = 1000;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       i2c_en;
  logic [3:0] i2c_sel;
  logic       i2c_done = 1'b0;
  logic [7:0] i2c_data = 8'h00;
  logic [3:0] rd_addr = 4'd13;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [15:0] frame_count;
  logic       overrun;
  logic       busy;
`ifdef MPU_SCHED_TIMEOUT_EN
  logic       timeout_err;
`endif

  mpu_read_scheduler #(
    .NUM_REGS      (NREG),
    .FIRST_SEL     (0),
    .PERIOD_CYCLES (PERIOD),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .i2c_en     (i2c_en),
    .i2c_sel    (i2c_sel),
    .i2c_done   (i2c_done),
    .i2c_data   (i2c_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .overrun    (overrun),
`ifdef MPU_SCHED_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .busy       (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int lat        = 50;
  int silent_sel = -1;
  int mcnt       = 0;
  logic [3:0] msel = 4'd0;
  int viol = 0;

  int n_en, n_done, n_fv;
  int en_cyc [64];
  int en_sel [64];
  int done_cyc [64];
  int fv_cyc [64];
  int fv_rd [64];
  int fv_ov [64];

  rd_vec_t tbl [16];

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Wrapper model and event log, evaluated mid-cycle.
  always @(negedge clk) begin
    i2c_done = 1'b0;
    if (rst) begin
      mcnt = 0;
    end else begin
      if (frame_valid) begin
        if (n_fv < 64) begin
          fv_cyc[n_fv] = cyc;
          fv_rd[n_fv]  = int'(rd_data);
          fv_ov[n_fv]  = int'(overrun);
        end
        n_fv++;
      end
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          i2c_done = 1'b1;
          i2c_data = 8'hA0 + 8'(msel);
          if (n_done < 64) done_cyc[n_done] = cyc;
          n_done++;
        end
      end
      if (i2c_en) begin
        if (mcnt > 0) viol++;
        if (n_en < 64) begin
          en_cyc[n_en] = cyc;
          en_sel[n_en] = int'(i2c_sel);
        end
        n_en++;
        msel = i2c_sel;
        if (int'(i2c_sel) != silent_sel) mcnt = lat;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    n_en = 0;
    n_done = 0;
    n_fv = 0;
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0:       return n_en;
      1:       return n_done;
      default: return n_fv;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int target, input int budget);
    int b;
    b = 0;
    while (get_cnt(which) < target && b < budget) begin
      @(posedge clk);
      b++;
    end
    #2;
    chk({name, "_reached"}, int'(get_cnt(which) >= target), 1);
  endtask

  task automatic check_bank(input string tag, input int ff_addr);
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = tbl[i].addr;
      #1;
      exp = (int'(tbl[i].addr) == ff_addr) ? 8'hFF : tbl[i].exp;
      chk($sformatf("%s_rd_data[%0d]", tag, i), int'(rd_data), int'(exp));
    end
    rd_addr = 4'd13;
  endtask

  initial begin
    int k;
    for (int a = 0; a < 16; a++) begin
      tbl[a].addr = 4'(a);
      tbl[a].exp  = (a < NREG) ? 8'(8'hA0 + a) : 8'h00;
    end
    clear_log();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_i2c_en", int'(i2c_en), 0);
    chk("rst_i2c_sel", int'(i2c_sel), 0);
    chk("rst_frame_valid", int'(frame_valid), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst = 1'b0;

    // Basic frame with latency checks
    @(negedge clk);
    enable = 1'b1;
    k = cyc;
    wait_cnt("basic_fv", 2, 1, 3000);
    repeat (5) @(posedge clk);
    #2;
    chk("basic_n_en", n_en, NREG);
    chk("basic_n_fv", n_fv, 1);
    chk("basic_frame_count", int'(frame_count), 1);
    chk("basic_first_en_after_tick", en_cyc[0], k + PERIOD);
    for (int i = 0; i < NREG; i++) chk($sformatf("basic_sel[%0d]", i), en_sel[i], i);
    for (int i = 1; i < NREG; i++)
      chk($sformatf("basic_done_to_en[%0d]", i), en_cyc[i] - done_cyc[i-1], 2);
    chk("basic_done_to_fv", fv_cyc[0] - done_cyc[NREG-1], 2);
    chk("basic_rd_at_fv", fv_rd[0], 8'hAD);
    chk("basic_overrun", int'(overrun), 0);
    chk("basic_busy_idle", int'(busy), 0);
`ifdef MPU_SCHED_TIMEOUT_EN
    chk("basic_timeout_err", int'(timeout_err), 0);
`endif
    check_bank("basic", -1);

    // Enable drops during read 5 of the next frame
    clear_log();
    wait_cnt("drop_en6", 0, 6, 2000);
    enable = 1'b0;
    wait_cnt("drop_done6", 1, 6, 200);
    repeat (100) @(posedge clk);
    #2;
    chk("drop_n_en", n_en, 6);
    chk("drop_last_sel", en_sel[5], 5);
    chk("drop_n_fv", n_fv, 0);
    chk("drop_frame_count", int'(frame_count), 1);
    chk("drop_busy", int'(busy), 0);
    check_bank("drop", -1);

    // Overrun: 80-cycle reads stretch a frame past one period
    clear_log();
    lat = 80;
    @(negedge clk);
    enable = 1'b1;
    k = cyc;
    wait_cnt("ovr_fv2", 2, 2, 5000);
    chk("ovr_first_en", en_cyc[0], k + PERIOD);
    chk("ovr_set_by_first_frame", fv_ov[0], 1);
    chk("ovr_second_frame_start", en_cyc[NREG] - en_cyc[0], 2 * PERIOD);
    chk("ovr_done_to_fv", fv_cyc[0] - done_cyc[NREG-1], 2);
    chk("ovr_frame_count", int'(frame_count), 3);
    chk("ovr_sticky", int'(overrun), 1);
    check_bank("ovr", -1);

    // Asynchronous reset while a read is outstanding
    clear_log();
    wait_cnt("arst_en", 0, 1, 3000);
    repeat (10) @(posedge clk);
    #2;
    chk("arst_pre_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_frame_count", int'(frame_count), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_i2c_en", int'(i2c_en), 0);
    chk("arst_i2c_sel", int'(i2c_sel), 0);
    chk("arst_frame_valid", int'(frame_valid), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    repeat (3) @(negedge clk);
    clear_log();
    lat = 50;
    rst = 1'b0;
    k = cyc;
    wait_cnt("arst_next_en", 0, 1, 2000);
    chk("arst_next_sel", en_sel[0], 0);
    chk("arst_next_en_time", en_cyc[0], k + PERIOD);

`ifdef MPU_SCHED_TIMEOUT_EN
    // Model never answers sel 3; watchdog substitutes 0xFF
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    silent_sel = 3;
    repeat (2) @(negedge clk);
    clear_log();
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    wait_cnt("to_fv", 2, 1, 3000);
    repeat (3) @(posedge clk);
    #2;
    chk("to_timeout_err", int'(timeout_err), 1);
    chk("to_frame_count", int'(frame_count), 1);
    chk("to_n_en", n_en, NREG);
    check_bank("to", 3);
`endif

    chk("no_en_while_outstanding", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
